// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: memory bus bundle between the requesters, the arbiter and the memory map
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8
);
    logic                  req_fetch;
    logic [ADDR_WIDTH-1:0] addr_fetch;
    logic                  req_exe;
    logic [ADDR_WIDTH-1:0] addr_exe;
    logic [REG_WIDTH-1:0]  wdata_exe;
    logic                  we_exe;
    logic                  req_dma;
    logic [ADDR_WIDTH-1:0] addr_dma;
    logic [REG_WIDTH-1:0]  wdata_dma;
    logic                  we_dma;
    logic                  gnt_fetch;
    logic                  gnt_exe;
    logic                  gnt_dma;
    logic                  rvalid_fetch;
    logic                  rvalid_exe;
    logic                  rvalid_dma;
    logic [REG_WIDTH-1:0]  rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic [1:0]            owner;

    modport slave (
        input  req_fetch, addr_fetch, req_exe, addr_exe, wdata_exe, we_exe,
        input  req_dma, addr_dma, wdata_dma, we_dma, mem_rdata,
        output gnt_fetch, gnt_exe, gnt_dma, rvalid_fetch, rvalid_exe, rvalid_dma,
        output rdata, mem_addr, mem_wdata, mem_we, owner
    );

    modport master (
        output req_fetch, addr_fetch, req_exe, addr_exe, wdata_exe, we_exe,
        output req_dma, addr_dma, wdata_dma, we_dma, mem_rdata,
        input  gnt_fetch, gnt_exe, gnt_dma, rvalid_fetch, rvalid_exe, rvalid_dma,
        input  rdata, mem_addr, mem_wdata, mem_we, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-port memory bus owner arbitrating instruction fetch, execute and DMA
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int REG_WIDTH    = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, OWN_FETCH, OWN_EXE, OWN_DMA, DMA_ALIGN} state_t;

    state_t                state_q, state_d, pick;
    logic                  cyc_odd_q, arb, fetch_first;
    logic                  acc_fetch, acc_exe, acc_dma;
    logic [7:0]            starve_cnt_q, starve_cnt_d;
    logic [2:0]            rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [REG_WIDTH-1:0]  mem_wdata_q, rdata_q;

    assign bus.gnt_fetch = state_q == OWN_FETCH;
    assign bus.gnt_exe   = state_q == OWN_EXE;
    assign bus.gnt_dma   = state_q == OWN_DMA;
    assign bus.owner     = bus.gnt_dma ? 2'd3 : bus.gnt_exe ? 2'd2 : {1'b0, bus.gnt_fetch};
    assign {bus.rvalid_dma, bus.rvalid_exe, bus.rvalid_fetch} = rvalid_q;
    assign bus.rdata     = rdata_q;

    assign acc_fetch = bus.gnt_fetch & bus.req_fetch;
    assign acc_exe   = bus.gnt_exe & bus.req_exe;
    assign acc_dma   = bus.gnt_dma & bus.req_dma;

    // Idle bus keeps the last address/data so the memory map sees no spurious toggling
    assign bus.mem_we    = (acc_exe & bus.we_exe) | (acc_dma & bus.we_dma);
    assign bus.mem_addr  = acc_fetch ? bus.addr_fetch : acc_exe ? bus.addr_exe : acc_dma ? bus.addr_dma : mem_addr_q;
    assign bus.mem_wdata = acc_exe ? bus.wdata_exe : acc_dma ? bus.wdata_dma : mem_wdata_q;
    assign rvalid_d      = {acc_dma & ~bus.we_dma, acc_exe & ~bus.we_exe, acc_fetch};

    assign fetch_first  = starve_cnt_q >= 8'(STARVE_LIMIT);
    assign starve_cnt_d = (bus.req_fetch & ~bus.gnt_fetch) ? starve_cnt_q + {7'd0, starve_cnt_q != 8'hff} : 8'd0;
    assign arb = (state_q == IDLE) | (bus.gnt_fetch & ~bus.req_fetch) | (bus.gnt_exe & ~bus.req_exe) | (bus.gnt_dma & ~bus.req_dma);

    // Next owner; cyc_odd_q flips at the edge, so a DMA win while odd lands on an even cycle
    always_comb begin
        pick    = (bus.req_fetch & fetch_first) ? OWN_FETCH : bus.req_exe ? OWN_EXE : bus.req_fetch ? OWN_FETCH : IDLE;
        state_d = state_q;
        if (state_q == DMA_ALIGN) state_d = bus.req_dma ? OWN_DMA : pick;
        else if (arb) state_d = !bus.req_dma ? pick : cyc_odd_q ? OWN_DMA : DMA_ALIGN;
    end

    // All state, including the registered read return path
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cyc_odd_q    <= 1'b0;
            starve_cnt_q <= 8'd0;
            rvalid_q     <= 3'b000;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cyc_odd_q    <= ~cyc_odd_q;
            starve_cnt_q <= starve_cnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= bus.mem_rdata;
            mem_addr_q   <= bus.mem_addr;
            mem_wdata_q  <= bus.mem_wdata;
        end
    end
endmodule
